// File: rtl/memory_sequencer.sv
// Memory-stage sequencer: walks CALL/RET/RTI/interrupt stack sequences
// and single-cycle loads/stores, stalling the pipeline while busy.
module memory_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       interrupt,
  input  logic       call_req,
  input  logic       ret_req,
  input  logic       rti_req,
  input  logic       ld_req,
  input  logic       st_req,
  output logic       busy,
  output logic       memory_read,
  output logic       memory_write,
  output logic       memory_push,
  output logic       memory_pop,
  output logic [1:0] memory_address_select,
  output logic [1:0] memory_write_src_select,
  output logic       pc_choose_memory,
  output logic       pc_load_hi,
  output logic       pc_load_lo,
  output logic       flags_restore,
  output logic       int_ack
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LDST,
    S_PUSH_HI,
    S_PUSH_LO,
    S_PUSH_FL,
    S_VEC_HI,
    S_VEC_LO,
    S_POP_FL,
    S_POP_LO,
    S_POP_HI,
    S_LOAD_PC
  } state_t;

  typedef enum logic [1:0] {
    OP_INT  = 2'b00,
    OP_CALL = 2'b01,
    OP_RET  = 2'b10,
    OP_RTI  = 2'b11
  } op_t;

  localparam logic [1:0] A_LDD = 2'b00;
  localparam logic [1:0] A_STD = 2'b01;
  localparam logic [1:0] A_SP  = 2'b10;
  localparam logic [1:0] A_VEC = 2'b11;

  localparam logic [1:0] W_REG  = 2'b00;
  localparam logic [1:0] W_PCHI = 2'b01;
  localparam logic [1:0] W_PCLO = 2'b10;
  localparam logic [1:0] W_FLG  = 2'b11;

  state_t r_state;
  state_t w_state_nxt;
  op_t    r_op;
  op_t    w_op_nxt;
  logic   r_is_st;
  logic   w_is_st_nxt;
  logic   r_int_pending;
  logic   w_int_take;
  logic   w_int_req;

  assign w_int_req = r_int_pending | interrupt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_op          <= OP_INT;
      r_is_st       <= 1'b0;
      r_int_pending <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_is_st <= w_is_st_nxt;
      // Taking the interrupt wins over a still-high level on that edge.
      if (w_int_take)
        r_int_pending <= 1'b0;
      else if (interrupt)
        r_int_pending <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_is_st_nxt = r_is_st;
    w_int_take  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_int_req) begin
          w_state_nxt = S_PUSH_HI;
          w_op_nxt    = OP_INT;
          w_int_take  = 1'b1;
        end else if (rti_req) begin
          w_state_nxt = S_POP_FL;
          w_op_nxt    = OP_RTI;
        end else if (ret_req) begin
          w_state_nxt = S_POP_LO;
          w_op_nxt    = OP_RET;
        end else if (call_req) begin
          w_state_nxt = S_PUSH_HI;
          w_op_nxt    = OP_CALL;
        end else if (ld_req) begin
          w_state_nxt = S_LDST;
          w_is_st_nxt = 1'b0;
        end else if (st_req) begin
          w_state_nxt = S_LDST;
          w_is_st_nxt = 1'b1;
        end
      end
      S_LDST:    w_state_nxt = S_IDLE;
      S_PUSH_HI: w_state_nxt = S_PUSH_LO;
      S_PUSH_LO: begin
        if (r_op == OP_INT)
          w_state_nxt = S_PUSH_FL;
        else
          w_state_nxt = S_LOAD_PC;
      end
      S_PUSH_FL: w_state_nxt = S_VEC_HI;
      S_VEC_HI:  w_state_nxt = S_VEC_LO;
      S_VEC_LO:  w_state_nxt = S_LOAD_PC;
      S_POP_FL:  w_state_nxt = S_POP_LO;
      S_POP_LO:  w_state_nxt = S_POP_HI;
      S_POP_HI:  w_state_nxt = S_LOAD_PC;
      S_LOAD_PC: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy                    = 1'b0;
    memory_read             = 1'b0;
    memory_write            = 1'b0;
    memory_push             = 1'b0;
    memory_pop              = 1'b0;
    memory_address_select   = A_LDD;
    memory_write_src_select = W_REG;
    pc_choose_memory        = 1'b0;
    pc_load_hi              = 1'b0;
    pc_load_lo              = 1'b0;
    flags_restore           = 1'b0;
    int_ack                 = 1'b0;
    unique case (r_state)
      S_IDLE: ;
      S_LDST: begin
        busy = 1'b1;
        if (r_is_st) begin
          memory_write          = 1'b1;
          memory_address_select = A_STD;
        end else begin
          memory_read = 1'b1;
        end
      end
      S_PUSH_HI: begin
        busy                    = 1'b1;
        memory_push             = 1'b1;
        memory_write            = 1'b1;
        memory_address_select   = A_SP;
        memory_write_src_select = W_PCHI;
      end
      S_PUSH_LO: begin
        busy                    = 1'b1;
        memory_push             = 1'b1;
        memory_write            = 1'b1;
        memory_address_select   = A_SP;
        memory_write_src_select = W_PCLO;
      end
      S_PUSH_FL: begin
        busy                    = 1'b1;
        memory_push             = 1'b1;
        memory_write            = 1'b1;
        memory_address_select   = A_SP;
        memory_write_src_select = W_FLG;
      end
      S_VEC_HI: begin
        busy                  = 1'b1;
        memory_read           = 1'b1;
        memory_address_select = A_VEC;
        pc_load_hi            = 1'b1;
      end
      S_VEC_LO: begin
        busy                  = 1'b1;
        memory_read           = 1'b1;
        memory_address_select = A_VEC;
        pc_load_lo            = 1'b1;
      end
      S_POP_FL: begin
        busy                  = 1'b1;
        memory_pop            = 1'b1;
        memory_read           = 1'b1;
        memory_address_select = A_SP;
        flags_restore         = 1'b1;
      end
      S_POP_LO: begin
        busy                  = 1'b1;
        memory_pop            = 1'b1;
        memory_read           = 1'b1;
        memory_address_select = A_SP;
        pc_load_lo            = 1'b1;
      end
      S_POP_HI: begin
        busy                  = 1'b1;
        memory_pop            = 1'b1;
        memory_read           = 1'b1;
        memory_address_select = A_SP;
        pc_load_hi            = 1'b1;
      end
      S_LOAD_PC: begin
        busy             = 1'b1;
        pc_choose_memory = (r_op != OP_CALL);
        int_ack          = (r_op == OP_INT);
      end
      default: ;
    endcase
  end

endmodule
